// File: rtl/demux_1ton_stream_if.sv
// demux_1ton_stream_if
// Bundles the upstream beat/select handshake, the N downstream channel
// handshakes and the drop counter of the 1-to-N stream demultiplexer.
// The slave modport is the demux's view, the master modport is the view
// of the surrounding producer/consumers.
interface demux_1ton_stream_if #(
  parameter int width = 16,
  parameter int n     = 4
);
  localparam int sw = (n > 1) ? $clog2(n) : 1;

  logic [width-1:0]   i;
  logic               i_valid;
  logic               i_ready;
  logic [sw-1:0]      sel;
  logic [n*width-1:0] o;
  logic [n-1:0]       o_valid;
  logic [n-1:0]       o_ready;
  logic [7:0]         drop_cnt;

  modport master (
    output i, i_valid, sel, o_ready,
    input  i_ready, o, o_valid, drop_cnt
  );

  modport slave (
    input  i, i_valid, sel, o_ready,
    output i_ready, o, o_valid, drop_cnt
  );
endinterface

// File: rtl/demux_1ton_stream.sv
// demux_1ton_stream
// Registered 1-to-N stream demultiplexer. Each output channel owns a
// one-entry register plus a full flag; a beat is captured into the channel
// chosen by sel and held until that consumer takes it. A channel that is
// draining in the same cycle can accept a new beat, so a single channel
// sustains one beat per clock. Beats whose select is out of range (only
// possible when n is not a power of two) are accepted and thrown away.
//
// Optional feature macro: DEMUX_DROP_CNT_EN
//   defined   -> drop_cnt counts discarded out-of-range beats, saturating
//                at 8'hFF, cleared only by rst.
//   undefined -> no counter is built and drop_cnt reads 8'h00.
module demux_1ton_stream #(
  parameter int width = 16,
  parameter int n     = 4
) (
  input  logic               clk,
  input  logic               rst,
  demux_1ton_stream_if.slave bus
);

  localparam int sw = (n > 1) ? $clog2(n) : 1;

  // Channel count widened by one bit so that n == 2**sw still fits.
  localparam logic [sw:0] L_NCH = (sw+1)'(n);

  logic [width-1:0] r_data [n];
  logic [n-1:0]     r_full;

  logic             w_inRange;
  logic [n-1:0]     w_selHot;
  logic [n-1:0]     w_chFree;
  logic             w_chReady;
  logic             w_iReady;
  logic             w_acc;
  logic [n-1:0]     w_load;

  // Decode the select into a one-hot channel vector; an out-of-range
  // select decodes to all zeros so it can never index a missing channel.
  assign w_inRange = ({1'b0, bus.sel} < L_NCH);

  for (genvar k = 0; k < n; k++) begin : g_dec
    assign w_selHot[k] = w_inRange && (bus.sel == sw'(k));
  end

  // A channel can take a beat when it is empty or is being drained at
  // this very edge; this keeps o_ready -> i_ready purely combinational.
  assign w_chFree  = ~r_full | bus.o_ready;
  assign w_chReady = |(w_selHot & w_chFree);
  assign w_iReady  = ~w_inRange | w_chReady;
  assign w_acc     = bus.i_valid & w_iReady;
  assign w_load    = w_acc ? w_selHot : '0;

  assign bus.i_ready = w_iReady;

  // Per-channel holding register: a load wins over a drain, a drain alone
  // empties the channel but leaves the last data in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < n; k++) begin
        r_data[k] <= '0;
      end
      r_full <= '0;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (w_load[k]) begin
          r_data[k] <= bus.i;
          r_full[k] <= 1'b1;
        end else if (r_full[k] && bus.o_ready[k]) begin
          r_full[k] <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < n; k++) begin : g_out
    assign bus.o[k*width +: width] = r_data[k];
  end

  assign bus.o_valid = r_full;

`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] r_dropCnt;

  // Count every accepted out-of-range beat, sticking at the top value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dropCnt <= 8'h00;
    end else if (w_acc && !w_inRange && (r_dropCnt != 8'hFF)) begin
      r_dropCnt <= r_dropCnt + 8'd1;
    end
  end

  assign bus.drop_cnt = r_dropCnt;
`else
  assign bus.drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_demux_1ton_stream.sv
// tb_demux_1ton_stream
// Drives a 16-bit / 4-channel demux through directed transfers while a
// scoreboard monitor checks every beat a consumer takes against the queue
// of beats the producer handed over. A second 3-channel instance exercises
// out-of-range selects and the optional drop counter (DEMUX_DROP_CNT_EN).
module tb_demux_1ton_stream;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  demux_1ton_stream_if #(.width(16), .n(4)) busA ();
  demux_1ton_stream_if #(.width(16), .n(3)) busB ();

  demux_1ton_stream #(.width(16), .n(4)) dutA (.clk(clk), .rst(rst), .bus(busA));
  demux_1ton_stream #(.width(16), .n(3)) dutB (.clk(clk), .rst(rst), .bus(busB));

`ifdef DEMUX_DROP_CNT_EN
  localparam logic [7:0] EXP_DROP3   = 8'd3;
  localparam logic [7:0] EXP_DROPSAT = 8'hFF;
`else
  localparam logic [7:0] EXP_DROP3   = 8'h00;
  localparam logic [7:0] EXP_DROPSAT = 8'h00;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] q3[$];

  // Single comparison point shared by stimulus and monitor.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic void pushExp(input int ch, input logic [15:0] d);
    case (ch)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endfunction

  task automatic popExp(input int ch, output logic [15:0] d, output bit ok);
    ok = 1'b1;
    d  = 16'h0;
    case (ch)
      0: if (q0.size() > 0) d = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) d = q1.pop_front(); else ok = 1'b0;
      2: if (q2.size() > 0) d = q2.pop_front(); else ok = 1'b0;
      default: if (q3.size() > 0) d = q3.pop_front(); else ok = 1'b0;
    endcase
  endtask

  function automatic void clearExp();
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
  endfunction

  // Scoreboard monitor: whenever a channel handshake is pending for the
  // next edge, the presented data must be the oldest beat sent there.
  always @(negedge clk) begin
    logic [15:0] expD;
    bit          ok;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (busA.o_valid[k] && busA.o_ready[k]) begin
          popExp(k, expD, ok);
          if (!ok) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL ch%0d unexpected beat: got %0h, expected none",
                     k, busA.o[k*16 +: 16]);
          end else begin
            checkOutput($sformatf("ch%0d data", k), 64'(busA.o[k*16 +: 16]), 64'(expD));
          end
        end
      end
    end
  end

  // Set the 4-channel producer/consumer inputs just after a rising edge.
  task automatic applyStimulus(input logic [3:0] rdy, input logic v,
                               input logic [1:0] s, input logic [15:0] d);
    @(posedge clk);
    #1;
    busA.o_ready = rdy;
    busA.i_valid = v;
    busA.sel     = s;
    busA.i       = d;
  endtask

  // Same for the 3-channel instance.
  task automatic applyStimulusB(input logic v, input logic [1:0] s,
                                input logic [15:0] d);
    @(posedge clk);
    #1;
    busB.i_valid = v;
    busB.sel     = s;
    busB.i       = d;
  endtask

  // Called at the falling edge: the beat on the bus must be taken, and
  // becomes an expected beat for its channel.
  task automatic acceptBeat(input string name);
    checkOutput(name, 64'(busA.i_ready), 64'd1);
    if (busA.i_valid && busA.i_ready) pushExp(int'(busA.sel), busA.i);
  endtask

  logic [15:0] vals [4] = '{16'hA000, 16'hB000, 16'hC000, 16'hD000};

  initial begin
    rst          = 1'b1;
    busA.i       = '0;
    busA.i_valid = 1'b0;
    busA.sel     = '0;
    busA.o_ready = 4'hF;
    busB.i       = '0;
    busB.i_valid = 1'b0;
    busB.sel     = '0;
    busB.o_ready = 3'b111;

    // Reset state.
    #2;
    checkOutput("reset o_valid", 64'(busA.o_valid), 64'd0);
    checkOutput("reset o", busA.o, 64'd0);
    checkOutput("reset i_ready", 64'(busA.i_ready), 64'd1);
    checkOutput("reset drop_cnt", 64'(busB.drop_cnt), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Streaming to every channel with all consumers ready.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'hF, 1'b1, 2'(k), vals[k]);
      @(negedge clk);
      acceptBeat($sformatf("stream i_ready beat%0d", k));
      checkOutput($sformatf("stream o_valid step%0d", k), 64'(busA.o_valid),
                  (k == 0) ? 64'd0 : 64'(4'b0001 << (k-1)));
    end
    applyStimulus(4'hF, 1'b0, 2'd0, 16'h0);
    @(negedge clk);
    checkOutput("stream o_valid step4", 64'(busA.o_valid), 64'(4'b1000));
    applyStimulus(4'hF, 1'b0, 2'd0, 16'h0);
    @(negedge clk);
    checkOutput("stream o_valid idle", 64'(busA.o_valid), 64'd0);

    // Back-pressure on channel 1.
    applyStimulus(4'b1101, 1'b1, 2'd1, 16'h1111);
    @(negedge clk);
    acceptBeat("bp first accept");
    for (int c = 0; c < 2; c++) begin
      applyStimulus(4'b1101, 1'b1, 2'd1, 16'h2222);
      @(negedge clk);
      checkOutput($sformatf("bp stalled i_ready c%0d", c), 64'(busA.i_ready), 64'd0);
      checkOutput($sformatf("bp held o_valid c%0d", c), 64'(busA.o_valid[1]), 64'd1);
      checkOutput($sformatf("bp held data c%0d", c), 64'(busA.o[16 +: 16]), 64'h1111);
    end
    applyStimulus(4'hF, 1'b1, 2'd1, 16'h2222);
    #1;
    checkOutput("bp same-cycle i_ready", 64'(busA.i_ready), 64'd1);
    @(negedge clk);
    acceptBeat("bp second accept");
    applyStimulus(4'hF, 1'b0, 2'd0, 16'h0);
    @(negedge clk);
    checkOutput("bp replace o_valid", 64'(busA.o_valid[1]), 64'd1);
    checkOutput("bp replace data", 64'(busA.o[16 +: 16]), 64'h2222);

    // Independence: stalled full channel 2 must not block channel 0.
    applyStimulus(4'b1011, 1'b1, 2'd2, 16'h5555);
    @(negedge clk);
    acceptBeat("ind ch2 accept");
    applyStimulus(4'b1011, 1'b1, 2'd0, 16'h3333);
    @(negedge clk);
    acceptBeat("ind ch0 accept");
    checkOutput("ind ch2 stays full", 64'(busA.o_valid[2]), 64'd1);
    applyStimulus(4'b1011, 1'b0, 2'd0, 16'h0);
    @(negedge clk);
    checkOutput("ind ch0 o_valid", 64'(busA.o_valid[0]), 64'd1);
    checkOutput("ind ch0 data", 64'(busA.o[15:0]), 64'h3333);

    // Fill channels 0 and 3 with consumers stalled, then reset mid-cycle.
    applyStimulus(4'b0000, 1'b1, 2'd0, 16'hAAAA);
    @(negedge clk);
    acceptBeat("rst fill ch0");
    applyStimulus(4'b0000, 1'b1, 2'd3, 16'hDDDD);
    @(negedge clk);
    acceptBeat("rst fill ch3");
    applyStimulus(4'b0000, 1'b0, 2'd0, 16'h0);
    @(negedge clk);
    checkOutput("rst pre o_valid", 64'(busA.o_valid), 64'(4'b1101));
    #2;
    rst = 1'b1;
    clearExp();
    #1;
    checkOutput("rst async o_valid", 64'(busA.o_valid), 64'd0);
    checkOutput("rst async o", busA.o, 64'd0);
    checkOutput("rst async i_ready", 64'(busA.i_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(4'hF, 1'b1, 2'd2, 16'h7777);
    @(negedge clk);
    acceptBeat("post-rst accept");
    applyStimulus(4'hF, 1'b0, 2'd0, 16'h0);
    @(negedge clk);
    checkOutput("post-rst o_valid", 64'(busA.o_valid), 64'(4'b0100));
    checkOutput("post-rst data", 64'(busA.o[32 +: 16]), 64'h7777);

    // Out-of-range selects on the 3-channel instance.
    for (int k = 0; k < 3; k++) begin
      applyStimulusB(1'b1, 2'd3, 16'(16'hE000 + k));
      @(negedge clk);
      checkOutput($sformatf("oor i_ready b%0d", k), 64'(busB.i_ready), 64'd1);
      checkOutput($sformatf("oor o_valid b%0d", k), 64'(busB.o_valid), 64'd0);
    end
    applyStimulusB(1'b0, 2'd0, 16'h0);
    @(negedge clk);
    checkOutput("oor drop_cnt 3", 64'(busB.drop_cnt), 64'(EXP_DROP3));
    checkOutput("oor o_valid after", 64'(busB.o_valid), 64'd0);

    // Saturation: 300 more discarded beats.
    for (int k = 0; k < 300; k++) begin
      applyStimulusB(1'b1, 2'd3, 16'(k));
    end
    applyStimulusB(1'b0, 2'd0, 16'h0);
    @(negedge clk);
    checkOutput("sat drop_cnt", 64'(busB.drop_cnt), 64'(EXP_DROPSAT));

    // In-range beat on the 3-channel instance leaves the counter alone.
    applyStimulusB(1'b1, 2'd1, 16'hBEEF);
    @(negedge clk);
    checkOutput("n3 in-range i_ready", 64'(busB.i_ready), 64'd1);
    applyStimulusB(1'b0, 2'd0, 16'h0);
    @(negedge clk);
    checkOutput("n3 in-range o_valid", 64'(busB.o_valid), 64'(3'b010));
    checkOutput("n3 in-range data", 64'(busB.o[16 +: 16]), 64'hBEEF);
    checkOutput("n3 drop_cnt unchanged", 64'(busB.drop_cnt), 64'(EXP_DROPSAT));

    // Every beat handed to the 4-channel instance must have come out.
    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained",
                64'(q0.size() + q1.size() + q2.size() + q3.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/demux_1ton_stream.md
# demux_1ton_stream

Registered, parametrised 1-to-N stream demultiplexer with per-channel valid/ready handshake and a one-entry output register per channel. It is the sequential successor of the combinational 1-to-4 data-flow demux, generalised in data width and channel count. A producer presents one beat plus a channel select; the beat is captured into the selected channel's register and held there until that consumer accepts it. It sits between a single upstream stream source and N independent downstream consumers.

## Interface
- `width`, 16, data bits per beat (≥1)
- `n`, 4, number of output channels (≥2); select width `sw` = ceil(log2 n)

- `clk`, in, 1, rising-edge clock
- `rst`, in, 1, asynchronous active-high reset
- `i`, in, width, input data beat
- `i_valid`, in, 1, input beat present
- `i_ready`, out, 1, input beat accepted this cycle when high with `i_valid`
- `sel`, in, sw, destination channel; sampled with `i` on acceptance
- `o`, out, n*width, channel k data is `o[k*width +: width]`
- `o_valid`, out, n, per-channel beat present
- `o_ready`, in, n, per-channel consumer accept
- `drop_cnt`, out, 8, count of discarded out-of-range beats (see Configuration)

## Operation
- Each channel k has one data register and a full flag; `o_valid[k]` = full flag.
- Input accept: `acc = i_valid & i_ready`.
- `i_ready` = 1 if `sel` ≥ n; otherwise `~o_valid[sel] | o_ready[sel]`. The path from `o_ready` to `i_ready` is combinational.
- On `acc` with `sel` < n: channel `sel` register loads `i`, full flag sets.
- On `o_valid[k] & o_ready[k]` with no load to k: full flag clears. Data register keeps its last value.
- Simultaneous drain and load on the same channel: new beat loads and the flag stays set. This gives full throughput of one beat per cycle.
- Channels are independent. A stalled channel never blocks beats aimed at other channels.
- While `o_valid[k]=1` and `o_ready[k]=0`, `o[k]` is held stable.
- Beat with `sel` ≥ n (only possible when n is not a power of 2): accepted and discarded. No channel changes.
- `i_valid=0`: `sel` and `i` are ignored, no state change.

## Timing
- Latency: a beat accepted at edge t is visible on `o`/`o_valid` after edge t. One cycle from acceptance to availability.
- Drain of channel k happens at the edge where `o_valid[k] & o_ready[k]`.
- Reset (async assert, any time): all `o_valid` = 0, all `o` = 0, `drop_cnt` = 0, buffered beats lost. `i_ready` then follows the combinational rule, so it is 1.
- Reset mid-operation: an in-flight beat is dropped without a partial update. The first edge after deassertion behaves as from empty.

## Configuration
- `DEMUX_DROP_CNT_EN` defined:
  - `drop_cnt` increments by 1 on every accepted beat with `sel` ≥ n.
  - It saturates at 8'hFF and clears only on `rst`.
- `DEMUX_DROP_CNT_EN` undefined:
  - The counter is not built and `drop_cnt` is tied to 8'h00.
  - Out-of-range beats are still accepted and discarded.

## Test plan
- width=16, n=4, all `o_ready`=1:
  - Stimulus: `i`=16'hA000/B000/C000/D000 with `sel`=0/1/2/3 on consecutive cycles, `i_valid`=1.
  - Required response: each value appears on its channel one cycle later with a one-cycle `o_valid` pulse; `i_ready` stays 1 throughout.
- Back-pressure:
  - Stimulus: `o_ready[1]`=0; send 16'h1111 to ch1, then 16'h2222 to ch1.
  - Required response: the first beat is held on ch1 and the second sees `i_ready`=0. Raising `o_ready[1]` gives `i_ready`=1 in the same cycle; 16'h2222 replaces 16'h1111 the next cycle with `o_valid[1]` remaining 1.
- Independence:
  - Stimulus: with ch2 stalled and full, send 16'h3333 to ch0.
  - Required response: the beat is accepted immediately and `o[0]`=16'h3333 the next cycle.
- Out-of-range, n=3, macro defined:
  - Stimulus: 3 beats with `sel`=3.
  - Required response: `i_ready`=1, no `o_valid` change, `drop_cnt`=3. With the macro undefined, `drop_cnt` stays 0.
- Reset:
  - Stimulus: assert `rst` mid-cycle with ch0 and ch3 full.
  - Required response: `o_valid` goes to 4'b0000 and `o` to all zeros immediately, without waiting for a clock edge; normal transfer resumes after deassertion.
- Saturation (macro defined, n=3):
  - Stimulus: 300 beats with `sel`=3.
  - Required response: `drop_cnt`=8'hFF.
